// File: rtl/edge_pulse_array.sv
// Multi-channel level-to-pulse converter: per-channel synchroniser, selectable
// edge detector (off/rise/fall/both), pulse stretcher and clearable sticky flag.
module edge_pulse_array #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 1,
    parameter int RETRIG      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     d,
    input  logic [2*N-1:0]   mode,
    input  logic [N-1:0]     clr,
    output logic [N-1:0]     q,
    output logic [N-1:0]     out,
    output logic [N-1:0]     sticky
);

    localparam int CW = $clog2(PULSE_W + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] s;
            logic                   q_d;
            logic                   rise;
            logic                   fall;
            logic                   evt;
            logic [CW-1:0]          cnt;
            logic                   stk;

            assign rise = s[SYNC_STAGES-1] & ~q_d;
            assign fall = ~s[SYNC_STAGES-1] & q_d;
            assign evt  = (mode[2*i] & rise) | (mode[2*i+1] & fall);

            always_ff @(posedge clk) begin
                if (rst) begin
                    s   <= '0;
                    q_d <= 1'b0;
                    cnt <= '0;
                    stk <= 1'b0;
                end else begin
                    s   <= {s[SYNC_STAGES-2:0], d[i]};
                    q_d <= s[SYNC_STAGES-1];
                    // Without retrigger, an edge inside a pulse only sets sticky.
                    if (evt && (cnt == '0 || RETRIG != 0)) begin
                        cnt <= CNT_LOAD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end
                    if (evt) begin
                        stk <= 1'b1;
                    end else if (clr[i]) begin
                        stk <= 1'b0;
                    end
                end
            end

            assign q[i]      = s[SYNC_STAGES-1];
            assign out[i]    = (cnt != '0);
            assign sticky[i] = stk;
        end
    endgenerate

endmodule

// File: tb/tb_edge_pulse_array.sv
// Scoreboard bench for edge_pulse_array: stimulus pushes cycle-stamped
// expectations, a monitor compares them after each clock edge.
module tb_edge_pulse_array;

    localparam int F_Q   = 0;
    localparam int F_OUT = 1;
    localparam int F_ST  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, rst3;
    logic [3:0] d0, clr0;
    logic [7:0] mode0;
    logic       d12, d3, d45;

    logic [3:0] q0, out0, st0;
    logic q1, out1, st1, q2, out2, st2, q3, out3, st3;
    logic q4, out4, st4, q5, out5, st5;

    // u0: base config; u1/u2: PULSE_W=4 retrig on/off; u3: PULSE_W=8; u4/u5: deeper sync
    edge_pulse_array #(.N(4), .SYNC_STAGES(2), .PULSE_W(1), .RETRIG(1)) u0 (
        .clk(clk), .rst(rst), .d(d0), .mode(mode0), .clr(clr0),
        .q(q0), .out(out0), .sticky(st0));
    edge_pulse_array #(.N(1), .SYNC_STAGES(2), .PULSE_W(4), .RETRIG(1)) u1 (
        .clk(clk), .rst(rst), .d(d12), .mode(2'b11), .clr(1'b0),
        .q(q1), .out(out1), .sticky(st1));
    edge_pulse_array #(.N(1), .SYNC_STAGES(2), .PULSE_W(4), .RETRIG(0)) u2 (
        .clk(clk), .rst(rst), .d(d12), .mode(2'b11), .clr(1'b0),
        .q(q2), .out(out2), .sticky(st2));
    edge_pulse_array #(.N(1), .SYNC_STAGES(2), .PULSE_W(8), .RETRIG(1)) u3 (
        .clk(clk), .rst(rst3), .d(d3), .mode(2'b01), .clr(1'b0),
        .q(q3), .out(out3), .sticky(st3));
    edge_pulse_array #(.N(1), .SYNC_STAGES(3), .PULSE_W(1), .RETRIG(1)) u4 (
        .clk(clk), .rst(rst), .d(d45), .mode(2'b01), .clr(1'b0),
        .q(q4), .out(out4), .sticky(st4));
    edge_pulse_array #(.N(1), .SYNC_STAGES(4), .PULSE_W(1), .RETRIG(1)) u5 (
        .clk(clk), .rst(rst), .d(d45), .mode(2'b01), .clr(1'b0),
        .q(q5), .out(out5), .sticky(st5));

    typedef struct {
        int         cyc;
        int         dut;
        int         fld;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [3:0] peek(input int dut, input int fld);
        logic [2:0] v;
        case (dut)
            0: return (fld == F_Q) ? q0 : (fld == F_OUT) ? out0 : st0;
            1: v = {st1, out1, q1};
            2: v = {st2, out2, q2};
            3: v = {st3, out3, q3};
            4: v = {st4, out4, q4};
            default: v = {st5, out5, q5};
        endcase
        return {3'b000, v[fld]};
    endfunction

    // Expect value val on (dut, fld) after edge cyc+j.
    task automatic ex(input int j, input int dut, input int fld,
                      input logic [3:0] val, input string name);
        exp_t e;
        e.cyc = cyc + j; e.dut = dut; e.fld = fld; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    logic [3:0] act;
                    act = peek(sb[i].dut, sb[i].fld);
                    n_checks++;
                    if (sb[i].cyc < cyc)
                        $display("FAIL %s: expectation for edge %0d checked late at edge %0d",
                                 sb[i].name, sb[i].cyc, cyc);
                    else if (act !== sb[i].val)
                        $display("FAIL %s: edge %0d u%0d got %b expected %b",
                                 sb[i].name, cyc, sb[i].dut, act, sb[i].val);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        d0 = 4'b0000; mode0 = 8'b01_01_01_01; clr0 = 4'b0000;
        d12 = 1'b0; d3 = 1'b0; d45 = 1'b0;

        // Reset state after the first edge
        ex(1, 0, F_Q,   4'b0000, "rst_q");
        ex(1, 0, F_OUT, 4'b0000, "rst_out");
        ex(1, 0, F_ST,  4'b0000, "rst_sticky");
        for (int u = 1; u <= 5; u++) ex(1, u, F_OUT, 4'b0000, "rst_out_ch");
        step(1);
        rst = 1'b0; rst3 = 1'b0;

        // Basic latency on ch0, and sync depth sweep on u4/u5
        d0 = 4'b0001; d45 = 1'b1;
        ex(1, 0, F_Q,   4'b0000, "lat_q_early");
        ex(2, 0, F_Q,   4'b0001, "lat_q");
        ex(2, 0, F_OUT, 4'b0000, "lat_out_early");
        ex(3, 0, F_OUT, 4'b0001, "lat_out");
        ex(3, 0, F_ST,  4'b0001, "lat_sticky");
        ex(4, 0, F_OUT, 4'b0000, "lat_out_end");
        ex(3, 4, F_OUT, 4'b0000, "ss3_early");
        ex(4, 4, F_OUT, 4'b0001, "ss3_out");
        ex(5, 4, F_OUT, 4'b0000, "ss3_end");
        ex(4, 5, F_OUT, 4'b0000, "ss4_early");
        ex(5, 5, F_OUT, 4'b0001, "ss4_out");
        ex(6, 5, F_OUT, 4'b0000, "ss4_end");
        step(4);

        // Mode coverage: ch0 off, ch1 rise, ch2 fall, ch3 both
        d0 = 4'b0000; mode0 = 8'b11_10_01_00; clr0 = 4'b1111;
        ex(1, 0, F_ST, 4'b0000, "clr_all");
        step(1);
        clr0 = 4'b0000;
        step(3);
        d0 = 4'b1111;
        ex(2, 0, F_Q,   4'b1111, "mode_q_hi");
        ex(2, 0, F_OUT, 4'b0000, "mode_rise_early");
        ex(3, 0, F_OUT, 4'b1010, "mode_rise_out");
        ex(3, 0, F_ST,  4'b1010, "mode_rise_sticky");
        ex(4, 0, F_OUT, 4'b0000, "mode_rise_end");
        step(5);
        d0 = 4'b0000;
        ex(2, 0, F_Q,   4'b0000, "mode_q_lo");
        ex(2, 0, F_OUT, 4'b0000, "mode_fall_early");
        ex(3, 0, F_OUT, 4'b1100, "mode_fall_out");
        ex(3, 0, F_ST,  4'b1110, "mode_sticky");
        ex(4, 0, F_OUT, 4'b0000, "mode_fall_end");
        step(4);

        // Sticky clear race on ch1: set beats clear, then clear takes effect
        d0 = 4'b0010;
        step(2);
        clr0 = 4'b0010;
        ex(1, 0, F_OUT, 4'b0010, "race_out");
        ex(1, 0, F_ST,  4'b1110, "race_set_wins");
        ex(2, 0, F_ST,  4'b1100, "race_clr");
        step(2);
        clr0 = 4'b0000;
        d0 = 4'b0000;
        step(4);

        // Stretch/retrigger: rise then fall two cycles apart, PULSE_W=4
        d12 = 1'b1;
        for (int j = 2; j <= 10; j++) begin
            ex(j, 1, F_OUT, {3'b000, (j >= 3 && j <= 8)}, "retrig1_out");
            ex(j, 2, F_OUT, {3'b000, (j >= 3 && j <= 6)}, "retrig0_out");
        end
        ex(5, 2, F_ST, 4'b0001, "retrig0_sticky");
        step(2);
        d12 = 1'b0;
        step(10);

        // Reset mid-pulse on u3 (PULSE_W=8), d held high through reset
        d3 = 1'b1;
        for (int j = 1; j <= 19; j++)
            ex(j, 3, F_OUT, {3'b000, (j == 3 || j == 4 || (j >= 8 && j <= 15))}, "midrst_out");
        ex(4, 3, F_ST, 4'b0001, "midrst_sticky_pre");
        ex(5, 3, F_ST, 4'b0000, "midrst_sticky");
        ex(8, 3, F_ST, 4'b0001, "midrst_sticky_post");
        step(4);
        rst3 = 1'b1;
        step(1);
        rst3 = 1'b0;
        step(20);

        for (int k = 0; k < 50 && sb.size() != 0; k++) step(1);
        foreach (sb[i]) begin
            n_checks++;
            $display("FAIL %s: expectation for edge %0d never checked", sb[i].name, sb[i].cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
